// File: rtl/fc_argmax_classifier_pkg.sv
`default_nettype none
// fc_argmax_classifier_pkg: shared FSM state type, class-index width helper and signed clamp.
package fc_argmax_classifier_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int SAT_CALC_W = 64;

  function automatic int class_idx_w(input int classes);
    return (classes < 2) ? 1 : $clog2(classes);
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_signed(
    input logic signed [SAT_CALC_W-1:0] val,
    input int                           width
  );
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_argmax_classifier_if.sv
`default_nettype none
// fc_argmax_classifier_if: framed logit input stream plus valid/ready result and error pulses.
// Define FC_ARGMAX_TOP2_EN to add the runner-up class and score signals.
interface fc_argmax_classifier_if
  import fc_argmax_classifier_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int CLASSES   = 64,
  parameter int OUT_WIDTH = 16
);
  localparam int CLASS_W = class_idx_w(CLASSES);

  logic signed [IN_WIDTH-1:0]  i_data;
  logic                        i_valid;
  logic                        i_sop;
  logic                        i_eop;
  logic [CLASS_W-1:0]          o_class;
  logic signed [OUT_WIDTH-1:0] o_score;
  logic                        o_sat;
  logic                        o_valid;
  logic                        i_ready;
  logic                        o_overrun;
  logic                        o_err_len;
  logic                        o_err_sop;
`ifdef FC_ARGMAX_TOP2_EN
  logic [CLASS_W-1:0]          o_class2;
  logic signed [OUT_WIDTH-1:0] o_score2;

  modport slave (
    input  i_data, i_valid, i_sop, i_eop, i_ready,
    output o_class, o_score, o_sat, o_valid, o_overrun, o_err_len, o_err_sop,
    output o_class2, o_score2
  );
  modport master (
    output i_data, i_valid, i_sop, i_eop, i_ready,
    input  o_class, o_score, o_sat, o_valid, o_overrun, o_err_len, o_err_sop,
    input  o_class2, o_score2
  );
`else
  modport slave (
    input  i_data, i_valid, i_sop, i_eop, i_ready,
    output o_class, o_score, o_sat, o_valid, o_overrun, o_err_len, o_err_sop
  );
  modport master (
    output i_data, i_valid, i_sop, i_eop, i_ready,
    input  o_class, o_score, o_sat, o_valid, o_overrun, o_err_len, o_err_sop
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fc_argmax_classifier_saturate.sv
`default_nettype none
// signed_saturate: combinational clamp of a signed IN_WIDTH value into OUT_WIDTH with a clip flag.
module signed_saturate
  import fc_argmax_classifier_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);
  logic signed [SAT_CALC_W-1:0] wide;
  logic signed [SAT_CALC_W-1:0] clamped;

  assign wide    = SAT_CALC_W'(din);
  assign clamped = sat_signed(wide, OUT_WIDTH);
  assign dout    = clamped[OUT_WIDTH-1:0];
  assign sat     = (clamped != wide);

endmodule
`default_nettype wire

// File: rtl/fc_argmax_classifier.sv
`default_nettype none
// fc_argmax_classifier: argmax over a framed packet of CLASSES signed logits, result held on valid/ready.
// Define FC_ARGMAX_TOP2_EN to also report the runner-up class and score.
module fc_argmax_classifier
  import fc_argmax_classifier_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int CLASSES   = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  fc_argmax_classifier_if.slave bus
);
  localparam int                 CLASS_W  = class_idx_w(CLASSES);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(CLASSES - 1);
  localparam logic [CLASS_W-1:0] ONE_IDX  = CLASS_W'(1);

  state_t                      state;
  logic [CLASS_W-1:0]          cnt;
  logic signed [IN_WIDTH-1:0]  best;
  logic [CLASS_W-1:0]          best_idx;
  logic                        res_valid;
  logic [CLASS_W-1:0]          res_class;
  logic signed [OUT_WIDTH-1:0] res_score;
  logic                        res_sat;
  logic                        overrun;
  logic                        err_len;
  logic                        err_sop;

  logic                        accum_beat;
  logic                        good_end;
  logic                        take_result;
  logic                        beat_gt_best;
  logic signed [IN_WIDTH-1:0]  nxt_best;
  logic [CLASS_W-1:0]          nxt_idx;
  logic signed [OUT_WIDTH-1:0] sat_score;
  logic                        sat_flag;

  // Running best including the current beat; the commit path saturates this view.
  assign accum_beat   = bus.i_valid && !bus.i_sop && (state == ACCUM);
  assign good_end     = accum_beat && bus.i_eop && (cnt == LAST_IDX);
  assign take_result  = !res_valid || bus.i_ready;
  assign beat_gt_best = bus.i_data > best;
  assign nxt_best     = beat_gt_best ? bus.i_data : best;
  assign nxt_idx      = beat_gt_best ? cnt : best_idx;

  signed_saturate #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_best (
    .din  (nxt_best),
    .dout (sat_score),
    .sat  (sat_flag)
  );

`ifdef FC_ARGMAX_TOP2_EN
  logic signed [IN_WIDTH-1:0]  second;
  logic [CLASS_W-1:0]          second_idx;
  logic signed [IN_WIDTH-1:0]  nxt_second;
  logic [CLASS_W-1:0]          nxt_second_idx;
  logic                        take_second;
  logic [CLASS_W-1:0]          res_class2;
  logic signed [OUT_WIDTH-1:0] res_score2;
  logic signed [OUT_WIDTH-1:0] sat_score2;

  // The second beat always seeds the runner-up; beats equal to best fall through to it.
  assign take_second = (cnt == ONE_IDX) || (bus.i_data > second);

  always_comb begin
    nxt_second     = second;
    nxt_second_idx = second_idx;
    if (beat_gt_best) begin
      nxt_second     = best;
      nxt_second_idx = best_idx;
    end else if (take_second) begin
      nxt_second     = bus.i_data;
      nxt_second_idx = cnt;
    end
  end

  signed_saturate #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_second (
    .din  (nxt_second),
    .dout (sat_score2),
    .sat  ()
  );

  assign bus.o_class2 = res_class2;
  assign bus.o_score2 = res_score2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      best       <= '0;
      best_idx   <= '0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
      res_sat    <= 1'b0;
      overrun    <= 1'b0;
      err_len    <= 1'b0;
      err_sop    <= 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
      second     <= '0;
      second_idx <= '0;
      res_class2 <= '0;
      res_score2 <= '0;
`endif
    end else if (clk_en) begin
      overrun <= 1'b0;
      err_len <= 1'b0;
      err_sop <= 1'b0;

      if (res_valid && bus.i_ready) res_valid <= 1'b0;

      if (good_end) begin
        if (take_result) begin
          res_valid  <= 1'b1;
          res_class  <= nxt_idx;
          res_score  <= sat_score;
          res_sat    <= sat_flag;
`ifdef FC_ARGMAX_TOP2_EN
          res_class2 <= nxt_second_idx;
          res_score2 <= sat_score2;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            if (bus.i_sop) begin
              best     <= bus.i_data;
              best_idx <= '0;
              cnt      <= ONE_IDX;
              err_len  <= bus.i_eop;
              state    <= bus.i_eop ? IDLE : ACCUM;
            end else begin
              err_sop <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.i_valid) begin
            if (bus.i_sop) begin
              err_sop  <= 1'b1;
              best     <= bus.i_data;
              best_idx <= '0;
              cnt      <= ONE_IDX;
              if (bus.i_eop) begin
                err_len <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              best       <= nxt_best;
              best_idx   <= nxt_idx;
              cnt        <= cnt + ONE_IDX;
`ifdef FC_ARGMAX_TOP2_EN
              second     <= nxt_second;
              second_idx <= nxt_second_idx;
`endif
              if (bus.i_eop || (cnt == LAST_IDX)) begin
                state   <= IDLE;
                err_len <= !good_end;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_valid   = res_valid;
  assign bus.o_class   = res_class;
  assign bus.o_score   = res_score;
  assign bus.o_sat     = res_sat;
  assign bus.o_overrun = overrun;
  assign bus.o_err_len = err_len;
  assign bus.o_err_sop = err_sop;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_classifier.sv
`default_nettype none
// tb_fc_argmax_classifier: table vectors, hand-written corner sequences and random packets vs an argmax model.
// Runner-up checks are enabled when FC_ARGMAX_TOP2_EN is defined.
module tb_fc_argmax_classifier;
  localparam int IW = 24;
  localparam int NC = 4;
  localparam int OW = 16;

  typedef struct {
    int cls;
    int score;
    bit sat;
    int cls2;
    int score2;
  } res_t;

  typedef struct {
    int   d [NC];
    res_t r;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  fc_argmax_classifier_if #(.IN_WIDTH(IW), .CLASSES(NC), .OUT_WIDTH(OW)) bus ();

  fc_argmax_classifier #(.IN_WIDTH(IW), .CLASSES(NC), .OUT_WIDTH(OW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clamp_out(input int v);
    int lim;
    lim = 1 << (OW - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Reference: lowest-index maximum, then best of the remaining classes (lowest index on ties).
  function automatic res_t model(input int p [NC]);
    res_t r;
    int   top;
    int   run;
    top = 0;
    for (int i = 1; i < NC; i++) if (p[i] > p[top]) top = i;
    run = -1;
    for (int i = 0; i < NC; i++)
      if (i != top && (run < 0 || p[i] > p[run])) run = i;
    r.cls    = top;
    r.score  = clamp_out(p[top]);
    r.sat    = (r.score != p[top]);
    r.cls2   = run;
    r.score2 = clamp_out(p[run]);
    return r;
  endfunction

  function automatic vec_t mkv(input int a, input int b, input int c, input int d,
                               input int cls, input int score, input bit sat,
                               input int cls2, input int score2);
    vec_t v;
    v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
    v.r.cls = cls; v.r.score = score; v.r.sat = sat; v.r.cls2 = cls2; v.r.score2 = score2;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit v, input bit s, input bit e, input int d);
    bus.i_valid = v;
    bus.i_sop   = s;
    bus.i_eop   = e;
    bus.i_data  = d[IW-1:0];
    step();
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
  endtask

  task automatic stall_cycle(input bit freeze);
    int d;
    d = int'($urandom);
    clk_en      = !freeze;
    bus.i_valid = freeze ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.i_sop   = 1'($urandom_range(0, 1));
    bus.i_eop   = 1'($urandom_range(0, 1));
    bus.i_data  = d[IW-1:0];
    step();
    clk_en      = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
  endtask

  task automatic send_packet(input int p [NC], input bit stalls);
    for (int i = 0; i < NC; i++) begin
      if (stalls) begin
        int k;
        k = $urandom_range(0, 2);
        repeat (k) stall_cycle(1'($urandom_range(0, 1)));
      end
      beat(1'b1, i == 0, i == NC - 1, p[i]);
    end
  endtask

  task automatic check_result(input string tag, input res_t e);
    check({tag, "_valid"}, bus.o_valid, 1);
    check({tag, "_class"}, bus.o_class, e.cls);
    check({tag, "_score"}, bus.o_score, e.score);
    check({tag, "_sat"}, bus.o_sat, e.sat);
`ifdef FC_ARGMAX_TOP2_EN
    check({tag, "_class2"}, bus.o_class2, e.cls2);
    check({tag, "_score2"}, bus.o_score2, e.score2);
`endif
  endtask

  task automatic accept(input string tag);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check({tag, "_drop"}, bus.o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   pa [NC];
    int   pb [NC];
    int   p  [NC];
    res_t ea;
    res_t eb;
    res_t e;
    int   hold;
    int   mode;

    rst = 1'b1; clk_en = 1'b0;
    bus.i_valid = 1'b0; bus.i_sop = 1'b0; bus.i_eop = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", bus.o_valid, 0);
    check("rst_class", bus.o_class, 0);
    check("rst_score", bus.o_score, 0);
    check("rst_sat", bus.o_sat, 0);
    check("rst_overrun", bus.o_overrun, 0);
    check("rst_err_len", bus.o_err_len, 0);
    check("rst_err_sop", bus.o_err_sop, 0);
    rst = 1'b0; clk_en = 1'b1;
    step();

    tbl[0] = mkv(5, -3, 9, 2,                          2, 9, 1'b0,      0, 5);
    tbl[1] = mkv(7, 7, 1, 0,                           0, 7, 1'b0,      1, 7);
    tbl[2] = mkv(40000, 1, 2, 3,                       0, 32767, 1'b1,  3, 3);
    tbl[3] = mkv(-40000, -50000, -60000, -70000,       0, -32768, 1'b1, 1, -32768);
    tbl[4] = mkv(-1, -1, -1, -1,                       0, -1, 1'b0,     1, -1);
    tbl[5] = mkv(32767, 32768, -32768, -32769,         1, 32767, 1'b1,  0, 32767);
    tbl[6] = mkv(-8388608, -8388608, 8388607, 8388607, 2, 32767, 1'b1,  3, 32767);

    bus.i_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NC - 1; i++) beat(1'b1, i == 0, 1'b0, tbl[t].d[i]);
      check("tbl_pre_eop_valid", bus.o_valid, 0);
      beat(1'b1, 1'b0, 1'b1, tbl[t].d[NC-1]);
      check_result("tbl", tbl[t].r);
      step();
      check("tbl_accept_drop", bus.o_valid, 0);
    end
    bus.i_ready = 1'b0;

    // Short packet: eop on the third beat.
    beat(1'b1, 1'b1, 1'b0, 1);
    beat(1'b1, 1'b0, 1'b0, 2);
    beat(1'b1, 1'b0, 1'b1, 3);
    check("short_err_len", bus.o_err_len, 1);
    check("short_no_valid", bus.o_valid, 0);
    step();
    check("short_err_len_clear", bus.o_err_len, 0);
    pa = '{0, -5, -1, -2};
    send_packet(pa, 1'b0);
    check_result("after_short", model(pa));
    accept("after_short");

    // Long packet: last class arrives without eop.
    beat(1'b1, 1'b1, 1'b0, 10);
    for (int i = 1; i < NC; i++) beat(1'b1, 1'b0, 1'b0, 10 + i);
    check("long_err_len", bus.o_err_len, 1);
    check("long_no_valid", bus.o_valid, 0);

    // Orphan beat in IDLE, then sop mid-packet restarts.
    beat(1'b1, 1'b0, 1'b0, 55);
    check("orphan_err_sop", bus.o_err_sop, 1);
    beat(1'b1, 1'b1, 1'b0, 100);
    check("sop_start_no_err", bus.o_err_sop, 0);
    beat(1'b1, 1'b0, 1'b0, 200);
    pa = '{-7, 3, 3, -8};
    beat(1'b1, 1'b1, 1'b0, pa[0]);
    check("restart_err_sop", bus.o_err_sop, 1);
    beat(1'b1, 1'b0, 1'b0, pa[1]);
    beat(1'b1, 1'b0, 1'b0, pa[2]);
    beat(1'b1, 1'b0, 1'b1, pa[3]);
    check_result("restart", model(pa));
    accept("restart");

    // Held result, second packet completes -> overrun; then commit concurrent with accept.
    pa = '{5, -3, 9, 2};
    pb = '{1, 2, 3, 4};
    ea = model(pa);
    eb = model(pb);
    send_packet(pa, 1'b0);
    check_result("hold_a", ea);
    send_packet(pb, 1'b0);
    check("overrun_pulse", bus.o_overrun, 1);
    check_result("overrun_kept", ea);
    step();
    check("overrun_clear", bus.o_overrun, 0);
    check_result("overrun_kept2", ea);
    for (int i = 0; i < NC - 1; i++) beat(1'b1, i == 0, 1'b0, pb[i]);
    bus.i_ready = 1'b1;
    beat(1'b1, 1'b0, 1'b1, pb[NC-1]);
    check("swap_no_overrun", bus.o_overrun, 0);
    check_result("swap_b", eb);
    step();
    check("swap_drop", bus.o_valid, 0);
    bus.i_ready = 1'b0;

    // Freeze mid-packet with i_valid toggling.
    pa = '{-100, 50, 60, 60};
    beat(1'b1, 1'b1, 1'b0, pa[0]);
    beat(1'b1, 1'b0, 1'b0, pa[1]);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.i_valid = (k % 2 == 0);
      bus.i_sop   = 1'b1;
      bus.i_eop   = (k == 2);
      bus.i_data  = 24'h7FFFFF;
      step();
      check("freeze_no_err_sop", bus.o_err_sop, 0);
      check("freeze_no_valid", bus.o_valid, 0);
    end
    clk_en = 1'b1;
    bus.i_valid = 1'b0; bus.i_sop = 1'b0; bus.i_eop = 1'b0;
    beat(1'b1, 1'b0, 1'b0, pa[2]);
    beat(1'b1, 1'b0, 1'b1, pa[3]);
    check_result("freeze", model(pa));

    // Reset mid-packet while a result is held.
    beat(1'b1, 1'b1, 1'b0, 1000);
    beat(1'b1, 1'b0, 1'b0, 2000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_err_len", bus.o_err_len, 0);
    check("midrst_err_sop", bus.o_err_sop, 0);
    pa = '{-9, -4, -4, -20};
    send_packet(pa, 1'b0);
    check_result("after_rst", model(pa));
    accept("after_rst");

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NC; i++) begin
        case (mode)
          0:       p[i] = int'($urandom_range(0, 6)) - 3;
          1:       p[i] = int'($urandom_range(0, 100000)) - 50000;
          default: p[i] = int'($urandom_range(0, 32'hFFFFFF)) - 8388608;
        endcase
      end
      e = model(p);
      send_packet(p, 1'b1);
      check_result("rand", e);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        step();
        check_result("rand_hold", e);
      end
      accept("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
